spi_controller: RTL and testbench

SPI mode-0 initiator that drives the write-frame protocol consumed by the onboarding SPI peripheral, which configures the PWM peripheral's enable and duty-cycle registers. Each accepted command is serialised as one 16-bit frame: R/W bit, 7-bit address, then 8-bit data, all MSB first. The block drives nCS, SCLK and COPI, and uses a valid/ready command port. It serves as the bench/FPGA-side driver and as a reusable on-chip master for register access.

---
 rtl/spi_pkg.sv | 38 +++
 rtl/spi_controller.sv | 141 ++++++++++++++
 tb/tb_spi_controller.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI write-frame initiator.
//   Frame layout (16 bits, MSB first): [15] R/W, [14:8] address, [7:0] data.
//   Also carries the FSM state type and the PWM peripheral register map.
package spi_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned RW_BIT     = 15;
    localparam int unsigned ADDR_MSB   = 14;
    localparam int unsigned ADDR_LSB   = 8;
    localparam int unsigned DATA_MSB   = 7;

    localparam logic SPI_WRITE = 1'b1;

    // PWM peripheral register addresses
    localparam logic [6:0] EN_REG_OUT_7_0  = 7'h00;
    localparam logic [6:0] EN_REG_OUT_15_8 = 7'h01;
    localparam logic [6:0] EN_REG_PWM_7_0  = 7'h02;
    localparam logic [6:0] EN_REG_PWM_15_8 = 7'h03;
    localparam logic [6:0] PWM_DUTY_CYCLE  = 7'h04;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } spi_state_t;

    function automatic logic [FRAME_BITS-1:0] make_frame(
        input logic       write,
        input logic [6:0] addr,
        input logic [7:0] data
    );
        return {write, addr, data};
    endfunction

endpackage

// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 initiator emitting one 16-bit write frame per
// accepted command.
//   clk        system clock (rising edge)
//   rst        synchronous active-high reset
//   cmd_valid  command present          cmd_ready  high only in IDLE
//   cmd_write  frame bit 15             cmd_addr   frame bits 14:8
//   cmd_data   frame bits 7:0
//   busy       accept .. return to IDLE done       one-cycle pulse at nCS rise
//   sclk       SPI clock, idles low     copi       serial data out
//   ncs        chip select, active-low
// All outputs are registered. Every phase lasts CLK_DIV system clocks.
module spi_controller
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       copi,
    output logic       ncs
);

    localparam int unsigned        CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [3:0]         LAST_BIT = 4'(FRAME_BITS - 1);

    spi_state_t            state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [3:0]            bitcnt_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic                  cmd_ready_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  sclk_q;
    logic                  copi_q;
    logic                  ncs_q;

    logic phase_end;
    logic accept;

    assign phase_end = (cnt_q == CNT_LAST);
    assign accept    = cmd_valid && cmd_ready_q;

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sclk      = sclk_q;
    assign copi      = copi_q;
    assign ncs       = ncs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sclk_q      <= 1'b0;
            copi_q      <= 1'b0;
            ncs_q       <= 1'b1;
        end else begin
            done_q <= 1'b0;

            // The divider is held at zero in IDLE so SETUP starts a full phase.
            if (state_q == IDLE || phase_end) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shift_q     <= make_frame(cmd_write, cmd_addr, cmd_data);
                        ncs_q       <= 1'b0;
                        copi_q      <= cmd_write;
                        bitcnt_q    <= '0;
                        busy_q      <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        state_q     <= SETUP;
                    end
                end
                SETUP: begin
                    if (phase_end) begin
                        sclk_q  <= 1'b1;
                        state_q <= HIGH;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        sclk_q <= 1'b0;
                        if (bitcnt_q == LAST_BIT) begin
                            state_q <= HOLD;
                        end else begin
                            // Next bit is presented on the falling edge just issued.
                            shift_q  <= {shift_q[FRAME_BITS-2:0], 1'b0};
                            copi_q   <= shift_q[FRAME_BITS-2];
                            bitcnt_q <= bitcnt_q + 4'd1;
                            state_q  <= LOW;
                        end
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        sclk_q  <= 1'b1;
                        state_q <= HIGH;
                    end
                end
                HOLD: begin
                    if (phase_end) begin
                        ncs_q   <= 1'b1;
                        copi_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    if (phase_end) begin
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: a CLK_DIV=4 instance for frame and
// timing checks, plus a CLK_DIV=2 instance looped into a behavioural SPI
// peripheral / PWM register model.
module tb_spi_controller;
    import spi_pkg::*;

    localparam int DIV  = 4;
    localparam int DIV2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       cmd_valid, cmd_write, cmd_ready, busy, done, sclk, copi, ncs;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_data;

    logic       cmd_valid2, cmd_write2, cmd_ready2, busy2, done2, sclk2, copi2, ncs2;
    logic [6:0] cmd_addr2;
    logic [7:0] cmd_data2;

    spi_controller #(.CLK_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .busy(busy), .done(done), .sclk(sclk), .copi(copi), .ncs(ncs)
    );

    spi_controller #(.CLK_DIV(DIV2)) dut2 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
        .cmd_write(cmd_write2), .cmd_addr(cmd_addr2), .cmd_data(cmd_data2),
        .busy(busy2), .done(done2), .sclk(sclk2), .copi(copi2), .ncs(ncs2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Receiver-side view of dut: one record per completed nCS window
    typedef struct {
        logic [15:0] bits;
        int          rises;
        int          low;
        int          t_fall;
        int          t_rise;
    } frame_t;

    frame_t      frames[$];
    int          accepts[$];
    int          done_cnt   = 0;
    logic [15:0] m_cap      = '0;
    int          m_rises    = 0;
    int          m_low      = 0;
    int          m_tfall    = 0;
    logic        m_sclk_prev = 1'b0;
    logic        m_ncs_prev  = 1'b1;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            m_cap = '0; m_rises = 0; m_low = 0;
            m_sclk_prev = 1'b0; m_ncs_prev = 1'b1;
        end else begin
            if (cmd_valid && cmd_ready) accepts.push_back(cyc);
            if (done) done_cnt++;
            if (!ncs) begin
                if (m_ncs_prev) m_tfall = cyc;
                m_low++;
                if (sclk && !m_sclk_prev) begin
                    m_cap = {m_cap[14:0], copi};
                    m_rises++;
                end
            end
            if (ncs && !m_ncs_prev) begin
                frames.push_back('{m_cap, m_rises, m_low, m_tfall, cyc});
                m_cap = '0; m_rises = 0; m_low = 0;
            end
            m_sclk_prev = sclk;
            m_ncs_prev  = ncs;
        end
    end

    // Behavioural SPI peripheral + PWM register file on dut2
    logic [7:0]  regs [0:127];
    logic [7:0]  uo_out;
    int          frames2 = 0;
    int          lows2[$];
    logic [15:0] p_cap = '0;
    int          p_rises = 0;
    int          p_low = 0;
    logic        p_sclk_prev = 1'b0;
    logic        p_ncs_prev  = 1'b1;

    assign uo_out = regs[EN_REG_OUT_7_0];

    initial forever begin
        @(negedge clk);
        if (rst) begin
            p_cap = '0; p_rises = 0; p_low = 0;
            p_sclk_prev = 1'b0; p_ncs_prev = 1'b1;
        end else begin
            if (!ncs2) begin
                p_low++;
                if (sclk2 && !p_sclk_prev) begin
                    p_cap = {p_cap[14:0], copi2};
                    p_rises++;
                end
            end
            if (ncs2 && !p_ncs_prev) begin
                if (p_rises == 16 && p_cap[15] == SPI_WRITE) regs[p_cap[14:8]] = p_cap[7:0];
                lows2.push_back(p_low);
                frames2++;
                p_cap = '0; p_rises = 0; p_low = 0;
            end
            p_sclk_prev = sclk2;
            p_ncs_prev  = ncs2;
        end
    end

    // Reference: frame value from the field rules, by plain arithmetic
    function automatic logic [15:0] model_frame(input logic w, input logic [6:0] a, input logic [7:0] d);
        int v;
        v = (w ? 32768 : 0) + int'(a) * 256 + int'(d);
        return 16'(v);
    endfunction

    task automatic issue(input logic w, input logic [6:0] a, input logic [7:0] d, output bit ok);
        int budget;
        budget = 500;
        ok = 1'b0;
        @(posedge clk); #1;
        while (!cmd_ready && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (!cmd_ready) begin
            n_checks++; n_fail++;
            $display("FAIL issue_ready: cmd_ready=%b expected 1 within budget", cmd_ready);
            return;
        end
        cmd_write = w; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        ok = 1'b1;
    endtask

    task automatic issue2(input logic w, input logic [6:0] a, input logic [7:0] d);
        int budget;
        budget = 300;
        @(posedge clk); #1;
        while (!cmd_ready2 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        cmd_write2 = w; cmd_addr2 = a; cmd_data2 = d; cmd_valid2 = 1'b1;
        @(posedge clk); #1;
        cmd_valid2 = 1'b0;
    endtask

    task automatic wait_frames(input int target, output bit ok);
        int budget;
        budget = 1000;
        while (frames.size() < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        ok = (frames.size() >= target);
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL frame_timeout: frames=%0d expected %0d", frames.size(), target);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_data = '0;
        cmd_valid2 = 1'b0; cmd_write2 = 1'b0; cmd_addr2 = '0; cmd_data2 = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (ncs !== 1'b1)       begin n_fail++; $display("FAIL reset_ncs: got %b want 1", ncs); end
        n_checks++; if (sclk !== 1'b0)      begin n_fail++; $display("FAIL reset_sclk: got %b want 0", sclk); end
        n_checks++; if (copi !== 1'b0)      begin n_fail++; $display("FAIL reset_copi: got %b want 0", copi); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        rst = 1'b0;
    endtask

    task automatic test_single;
        bit ok;
        int base, d0, a0;
        frame_t f;
        base = frames.size(); d0 = done_cnt; a0 = accepts.size();
        issue(1'b1, 7'h04, 8'hA5, ok);
        wait_frames(base + 1, ok);
        if (!ok) return;
        f = frames[base];
        n_checks++; if (f.bits !== 16'h84A5) begin n_fail++; $display("FAIL single_bits: got %h want 84a5", f.bits); end
        n_checks++; if (f.rises != 16)       begin n_fail++; $display("FAIL single_rises: got %0d want 16", f.rises); end
        n_checks++; if (f.low != 33 * DIV)   begin n_fail++; $display("FAIL single_ncs_low: got %0d want %0d", f.low, 33 * DIV); end
        n_checks++; if (done_cnt - d0 != 1)  begin n_fail++; $display("FAIL single_done: got %0d want 1", done_cnt - d0); end
        n_checks++;
        if (accepts.size() != a0 + 1 || f.t_fall - accepts[a0] != 1 || f.t_rise - accepts[a0] != 1 + 33 * DIV) begin
            n_fail++;
            $display("FAIL single_timing: accepts=%0d fall=%0d rise=%0d want 1 accept, fall=+1 rise=+%0d",
                     accepts.size() - a0, f.t_fall - accepts[a0], f.t_rise - accepts[a0], 1 + 33 * DIV);
        end
        repeat (DIV + 2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL single_idle: busy=%b ready=%b want 0/1", busy, cmd_ready);
        end
    endtask

    task automatic test_random;
        bit ok;
        int base;
        logic w; logic [6:0] a; logic [7:0] d;
        for (int i = 0; i < 5; i++) begin
            w = 1'($urandom_range(0, 1)); a = 7'($urandom); d = 8'($urandom);
            base = frames.size();
            issue(w, a, d, ok);
            wait_frames(base + 1, ok);
            if (!ok) return;
            n_checks++; if (frames[base].bits !== model_frame(w, a, d)) begin
                n_fail++; $display("FAIL random_bits[%0d]: got %h want %h", i, frames[base].bits, model_frame(w, a, d));
            end
            n_checks++; if (frames[base].rises != 16 || frames[base].low != 33 * DIV) begin
                n_fail++; $display("FAIL random_shape[%0d]: rises=%0d low=%0d want 16/%0d", i, frames[base].rises, frames[base].low, 33 * DIV);
            end
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int fb, ab, budget;
        logic [6:0] a1, a2; logic [7:0] d1, d2;
        a1 = 7'($urandom); d1 = 8'($urandom); a2 = 7'($urandom); d2 = 8'($urandom);
        fb = frames.size(); ab = accepts.size();
        @(posedge clk); #1;
        cmd_write = 1'b1; cmd_addr = a1; cmd_data = d1; cmd_valid = 1'b1;
        budget = 600;
        while (accepts.size() < ab + 2 && budget > 0) begin
            @(posedge clk); #1;
            if (accepts.size() == ab + 1) begin cmd_addr = a2; cmd_data = d2; end
            budget--;
        end
        cmd_valid = 1'b0;
        wait_frames(fb + 2, ok);
        if (!ok) return;
        n_checks++; if (accepts.size() != ab + 2 || accepts[ab + 1] - accepts[ab] != 34 * DIV + 1) begin
            n_fail++; $display("FAIL b2b_period: accepts=%0d period=%0d want 2/%0d", accepts.size() - ab,
                               accepts[ab + 1] - accepts[ab], 34 * DIV + 1);
        end
        n_checks++; if (frames[fb].bits !== model_frame(1'b1, a1, d1)) begin
            n_fail++; $display("FAIL b2b_first: got %h want %h", frames[fb].bits, model_frame(1'b1, a1, d1));
        end
        n_checks++; if (frames[fb + 1].bits !== model_frame(1'b1, a2, d2)) begin
            n_fail++; $display("FAIL b2b_second: got %h want %h", frames[fb + 1].bits, model_frame(1'b1, a2, d2));
        end
        n_checks++; if (frames[fb + 1].t_fall - frames[fb].t_rise < DIV) begin
            n_fail++; $display("FAIL b2b_gap: ncs high %0d cycles want >= %0d", frames[fb + 1].t_fall - frames[fb].t_rise, DIV);
        end
    endtask

    task automatic test_input_stability;
        bit ok;
        int fb, ab, ready_seen;
        logic [6:0] a; logic [7:0] d;
        a = 7'($urandom); d = 8'($urandom);
        fb = frames.size(); ab = accepts.size();
        issue(1'b0, a, d, ok);
        ready_seen = 0;
        for (int i = 0; i < 80; i++) begin
            cmd_write = 1'($urandom); cmd_addr = 7'($urandom); cmd_data = 8'($urandom);
            cmd_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (cmd_ready !== 1'b0) ready_seen++;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        wait_frames(fb + 1, ok);
        if (!ok) return;
        n_checks++; if (frames[fb].bits !== model_frame(1'b0, a, d)) begin
            n_fail++; $display("FAIL stable_bits: got %h want %h", frames[fb].bits, model_frame(1'b0, a, d));
        end
        n_checks++; if (ready_seen != 0) begin
            n_fail++; $display("FAIL stable_ready: cmd_ready high %0d cycles mid-frame want 0", ready_seen);
        end
        n_checks++; if (accepts.size() != ab + 1) begin
            n_fail++; $display("FAIL stable_accepts: got %0d want 1", accepts.size() - ab);
        end
    endtask

    task automatic test_reset_mid_frame;
        bit ok;
        int fb, d0, budget;
        issue(1'b1, 7'($urandom), 8'($urandom), ok);
        budget = 300;
        while (m_rises < 7 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_checks++; if (m_rises != 7) begin n_fail++; $display("FAIL midrst_reach: rises=%0d want 7", m_rises); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        fb = frames.size(); d0 = done_cnt;
        n_checks++; if ({ncs, sclk, copi, cmd_ready, busy, done} !== 6'b100100) begin
            n_fail++; $display("FAIL midrst_idle: ncs,sclk,copi,ready,busy,done=%b want 100100", {ncs, sclk, copi, cmd_ready, busy, done});
        end
        repeat (40 * DIV) @(posedge clk);
        n_checks++; if (done_cnt != d0 || frames.size() != fb) begin
            n_fail++; $display("FAIL midrst_nodone: done=%0d frames=%0d want 0/0", done_cnt - d0, frames.size() - fb);
        end
        issue(1'b1, 7'h00, 8'hFF, ok);
        wait_frames(fb + 1, ok);
        if (!ok) return;
        n_checks++; if (frames[fb].bits !== 16'h80FF || frames[fb].rises != 16) begin
            n_fail++; $display("FAIL midrst_next: got %h rises=%0d want 80ff/16", frames[fb].bits, frames[fb].rises);
        end
    endtask

    task automatic test_loopback;
        int n0, budget;
        logic [6:0] a; logic [7:0] d;
        n0 = frames2;
        issue2(1'b1, EN_REG_OUT_7_0, 8'hFF);
        issue2(1'b1, PWM_DUTY_CYCLE, 8'h80);
        budget = 400;
        while (frames2 < n0 + 2 && budget > 0) begin @(negedge clk); budget--; end
        n_checks++; if (regs[EN_REG_OUT_7_0] !== 8'hFF || uo_out !== 8'hFF) begin
            n_fail++; $display("FAIL loop_en_out: reg=%h uo_out=%h want ff/ff", regs[EN_REG_OUT_7_0], uo_out);
        end
        n_checks++; if (regs[PWM_DUTY_CYCLE] !== 8'h80) begin
            n_fail++; $display("FAIL loop_duty: got %h want 80", regs[PWM_DUTY_CYCLE]);
        end
        n_checks++; if (lows2.size() < 1 || lows2[lows2.size() - 1] != 33 * DIV2) begin
            n_fail++; $display("FAIL loop_ncs_low: got %0d want %0d", lows2.size() > 0 ? lows2[lows2.size() - 1] : -1, 33 * DIV2);
        end
        for (int i = 0; i < 3; i++) begin
            a = 7'($urandom_range(1, 3)); d = 8'($urandom);
            n0 = frames2;
            issue2(1'b1, a, d);
            budget = 200;
            while (frames2 < n0 + 1 && budget > 0) begin @(negedge clk); budget--; end
            n_checks++; if (regs[a] !== d) begin
                n_fail++; $display("FAIL loop_reg[%0d]: addr %h got %h want %h", i, a, regs[a], d);
            end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_random;
        test_back_to_back;
        test_input_stability;
        test_reset_mid_frame;
        test_loopback;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
